// File: rtl/mux_sel_reg_n_pkg.sv
// Shared constants, types and helpers for the registered N-way source selector.
package mux_sel_reg_n_pkg;

   localparam int CONST_SP_INIT = 227;
   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } buf_state_t;

   // Minimum bits to encode n distinct values; one bit minimum.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << r) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_decode_n.sv
// Combinational channel decode: data_in channels, constant top channel, out-of-range fallback to channel 0.
module mux_decode_n
   import mux_sel_reg_n_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int N_IN      = 8,
   parameter int CONST_VAL = CONST_SP_INIT,
   localparam int SEL_W    = clog2(N_IN)
) (
   input  logic [SEL_W-1:0]            sel,
   input  logic [(N_IN-1)*WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]            value,
   output logic                        out_of_range
);

   logic [WIDTH-1:0] chan [N_IN];
   int               sel_i;

   for (genvar k = 0; k < N_IN - 1; k++) begin : g_chan
      assign chan[k] = data_in[k*WIDTH +: WIDTH];
   end
   assign chan[N_IN-1] = WIDTH'(CONST_VAL);

   // Loop compare keeps the index in range even when N_IN is not a power of two.
   always_comb begin
      sel_i        = int'({1'b0, sel});
      value        = chan[0];
      out_of_range = (sel_i >= N_IN);
      for (int k = 0; k < N_IN; k++) begin
         if (sel_i == k) value = chan[k];
      end
   end

endmodule

// File: rtl/mux_sel_reg_n.sv
// Registered N-way selector with a single-entry valid/ready output buffer,
// sticky out-of-range flag and wrapping capture counter.
//
//   state | meaning
//   EMPTY | no unconsumed capture; load is always accepted
//   FULL  | data_out holds a capture; load accepted only with out_ready
module mux_sel_reg_n
   import mux_sel_reg_n_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int N_IN      = 8,
   parameter int CONST_VAL = CONST_SP_INIT,
   parameter int CNT_W     = 16,
   localparam int SEL_W    = clog2(N_IN)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SEL_W-1:0]            sel,
   input  logic [(N_IN-1)*WIDTH-1:0]   data_in,
   input  logic                        load,
   output logic                        load_ready,
   output logic [WIDTH-1:0]            data_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        sel_err,
   input  logic                        clear_err,
   output logic [CNT_W-1:0]            cap_count
);

   buf_state_t       state;
   logic [WIDTH-1:0] dec_value;
   logic             dec_oor;
   logic             accept;

   mux_decode_n #(
      .WIDTH     (WIDTH),
      .N_IN      (N_IN),
      .CONST_VAL (CONST_VAL)
   ) u_decode (
      .sel          (sel),
      .data_in      (data_in),
      .value        (dec_value),
      .out_of_range (dec_oor)
   );

   assign out_valid  = (state == FULL);
   assign load_ready = !out_valid || out_ready;
   assign accept     = load && load_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         data_out  <= '0;
         out_sel   <= '0;
         sel_err   <= 1'b0;
         cap_count <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) state <= FULL;
            FULL:  if (out_ready && !accept) state <= EMPTY;
            default: state <= EMPTY;
         endcase

         if (accept) begin
            data_out  <= dec_value;
            out_sel   <= sel;
            cap_count <= cap_count + CNT_W'(1);
         end

         // A new error outranks a clear arriving in the same cycle.
         if (accept && dec_oor) sel_err <= 1'b1;
         else if (clear_err)    sel_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_sel_reg_n.sv
// Self-checking bench: directed plan plus randomized traffic against a behavioural model,
// on an 8-channel 32-bit instance and a 6-channel 8-bit instance.
module tb_mux_sel_reg_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: N_IN=8, WIDTH=32, CNT_W=4
   logic          reset_a, load_a, out_ready_a, clear_a;
   logic [2:0]    sel_a;
   logic [31:0]   ch_a [7];
   logic [223:0]  data_in_a;
   logic          load_ready_a, out_valid_a, sel_err_a;
   logic [31:0]   data_out_a;
   logic [2:0]    out_sel_a;
   logic [3:0]    cap_count_a;

   // Instance B: N_IN=6, WIDTH=8, CNT_W=4
   logic          reset_b, load_b, out_ready_b, clear_b;
   logic [2:0]    sel_b;
   logic [7:0]    ch_b [5];
   logic [39:0]   data_in_b;
   logic          load_ready_b, out_valid_b, sel_err_b;
   logic [7:0]    data_out_b;
   logic [2:0]    out_sel_b;
   logic [3:0]    cap_count_b;

   always_comb begin
      data_in_a = '0;
      for (int k = 0; k < 7; k++) data_in_a[k*32 +: 32] = ch_a[k];
      data_in_b = '0;
      for (int k = 0; k < 5; k++) data_in_b[k*8 +: 8] = ch_b[k];
   end

   mux_sel_reg_n #(.WIDTH(32), .N_IN(8), .CONST_VAL(227), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset_a), .sel(sel_a), .data_in(data_in_a), .load(load_a),
      .load_ready(load_ready_a), .data_out(data_out_a), .out_valid(out_valid_a),
      .out_ready(out_ready_a), .out_sel(out_sel_a), .sel_err(sel_err_a),
      .clear_err(clear_a), .cap_count(cap_count_a)
   );

   mux_sel_reg_n #(.WIDTH(8), .N_IN(6), .CONST_VAL(227), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset_b), .sel(sel_b), .data_in(data_in_b), .load(load_b),
      .load_ready(load_ready_b), .data_out(data_out_b), .out_valid(out_valid_b),
      .out_ready(out_ready_b), .out_sel(out_sel_b), .sel_err(sel_err_b),
      .clear_err(clear_b), .cap_count(cap_count_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one "held capture" record per instance.
   bit          m_valid_a, m_err_a, m_valid_b, m_err_b;
   logic [31:0] m_data_a;
   logic [7:0]  m_data_b;
   int          m_sel_a, m_sel_b, m_cnt_a, m_cnt_b;

   function automatic logic [31:0] pick_a(input int s);
      if (s == 7) return 32'd227;
      return ch_a[s];
   endfunction

   function automatic logic [7:0] pick_b(input int s);
      if (s == 5) return 8'd227;
      if (s > 5)  return ch_b[0];
      return ch_b[s];
   endfunction

   task automatic tick();
      bit acc_a, acc_b;
      #1;
      chk("ready_a", load_ready_a, !m_valid_a || out_ready_a);
      chk("ready_b", load_ready_b, !m_valid_b || out_ready_b);
      acc_a = load_a && (!m_valid_a || out_ready_a);
      acc_b = load_b && (!m_valid_b || out_ready_b);
      @(posedge clk);
      if (reset_a) begin
         m_valid_a = 0; m_err_a = 0; m_data_a = '0; m_sel_a = 0; m_cnt_a = 0;
      end else if (acc_a) begin
         m_data_a = pick_a(int'(sel_a)); m_sel_a = int'(sel_a);
         m_valid_a = 1; m_cnt_a = (m_cnt_a + 1) % 16;
         if (clear_a) m_err_a = 0;
      end else begin
         if (out_ready_a) m_valid_a = 0;
         if (clear_a) m_err_a = 0;
      end
      if (reset_b) begin
         m_valid_b = 0; m_err_b = 0; m_data_b = '0; m_sel_b = 0; m_cnt_b = 0;
      end else begin
         if (clear_b) m_err_b = 0;
         if (acc_b) begin
            m_data_b = pick_b(int'(sel_b)); m_sel_b = int'(sel_b);
            m_valid_b = 1; m_cnt_b = (m_cnt_b + 1) % 16;
            if (sel_b > 3'd5) m_err_b = 1;
         end else if (out_ready_b) m_valid_b = 0;
      end
      #1;
      chk("data_a", data_out_a, m_data_a);
      chk("valid_a", out_valid_a, m_valid_a);
      chk("sel_a", out_sel_a, m_sel_a);
      chk("err_a", sel_err_a, m_err_a);
      chk("cnt_a", cap_count_a, m_cnt_a);
      chk("data_b", data_out_b, m_data_b);
      chk("valid_b", out_valid_b, m_valid_b);
      chk("sel_b", out_sel_b, m_sel_b);
      chk("err_b", sel_err_b, m_err_b);
      chk("cnt_b", cap_count_b, m_cnt_b);
   endtask

   initial begin
      reset_a = 1; load_a = 1; sel_a = 3'd2; out_ready_a = 0; clear_a = 0;
      reset_b = 1; load_b = 1; sel_b = 3'd1; out_ready_b = 0; clear_b = 0;
      for (int k = 0; k < 7; k++) ch_a[k] = 32'h100 + k;
      for (int k = 0; k < 5; k++) ch_b[k] = 8'h10 + 8'(k);
      m_valid_a = 0; m_err_a = 0; m_data_a = '0; m_sel_a = 0; m_cnt_a = 0;
      m_valid_b = 0; m_err_b = 0; m_data_b = '0; m_sel_b = 0; m_cnt_b = 0;

      // Reset held two cycles with load asserted
      tick(); tick();
      chk("rst_data", data_out_a, 0);
      chk("rst_cnt", cap_count_a, 0);
      reset_a = 0; reset_b = 0; load_b = 0;

      // Channel sweep
      out_ready_a = 1;
      for (int s = 0; s < 8; s++) begin
         sel_a = 3'(s);
         tick();
         chk("sweep_val", data_out_a, (s == 7) ? 32'd227 : 32'h100 + s);
      end
      chk("sweep_cnt", cap_count_a, 8);
      load_a = 0;
      tick();

      // Backpressure
      out_ready_a = 0; load_a = 1; sel_a = 3'd3;
      tick();
      chk("bp_ready", load_ready_a, 0);
      sel_a = 3'd5;
      repeat (3) tick();
      chk("bp_hold", data_out_a, 32'h103);
      out_ready_a = 1;
      tick();
      chk("bp_new", data_out_a, 32'h105);
      chk("bp_valid", out_valid_a, 1);

      // Drain
      load_a = 0;
      tick();
      chk("drain_valid", out_valid_a, 0);
      chk("drain_hold", data_out_a, 32'h105);

      // Out-of-range on 6-channel instance
      out_ready_b = 1; load_b = 1; sel_b = 3'd7;
      tick();
      chk("oor_data", data_out_b, 8'h10);
      chk("oor_err", sel_err_b, 1);
      sel_b = 3'd6; clear_b = 1;
      tick();
      chk("oor_setwins", sel_err_b, 1);
      load_b = 0;
      tick();
      chk("oor_clear", sel_err_b, 0);
      clear_b = 0; load_b = 1; sel_b = 3'd5;
      tick();
      chk("oor_const", data_out_b, 8'd227);
      chk("oor_inrange", sel_err_b, 0);
      load_b = 0;

      // Counter wrap then reset mid-burst
      reset_a = 1; tick(); reset_a = 0;
      load_a = 1; out_ready_a = 1;
      for (int i = 0; i < 17; i++) begin
         sel_a = 3'(i % 8);
         tick();
      end
      chk("wrap_cnt", cap_count_a, 1);
      repeat (2) tick();
      reset_a = 1;
      tick();
      chk("midrst_valid", out_valid_a, 0);
      chk("midrst_data", data_out_a, 0);
      chk("midrst_cnt", cap_count_a, 0);
      reset_a = 0;

      // Randomized traffic on both instances
      for (int i = 0; i < 400; i++) begin
         reset_a = ($urandom_range(0, 50) == 0);
         reset_b = ($urandom_range(0, 50) == 0);
         load_a = $urandom_range(0, 3) != 0;
         load_b = $urandom_range(0, 3) != 0;
         out_ready_a = $urandom_range(0, 2) != 0;
         out_ready_b = $urandom_range(0, 2) != 0;
         clear_a = $urandom_range(0, 7) == 0;
         clear_b = $urandom_range(0, 5) == 0;
         sel_a = 3'($urandom_range(0, 7));
         sel_b = 3'($urandom_range(0, 7));
         for (int k = 0; k < 7; k++) ch_a[k] = $urandom;
         for (int k = 0; k < 5; k++) ch_b[k] = 8'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
